gpio_m2f_conditioner: RTL and testbench

- Fabric-side stage directly downstream of the MSS GPIO_0_M2F / GPIO_1_M2F outputs.
- Resynchronises and debounces both GPIO lines into the fabric clock domain, and detects their edges.
- Counts events per channel and produces the registered NOR result Y consumed by the board output.
- Outputs are gated until MSS_READY is stable, so no spurious activity occurs during MSS boot.

---
 rtl/gpio_m2f_conditioner_if.sv | 34 +++
 rtl/gpio_m2f_conditioner.sv | 209 ++++++++++++++++++++
 tb/tb_gpio_m2f_conditioner.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_m2f_conditioner_if.sv
// ---------------------------------------------------------------------------
// gpio_m2f_conditioner_if
// Bundles the MSS-facing inputs and the conditioned fabric outputs of
// gpio_m2f_conditioner.
//   master : drives MSS_READY, GPIO_0_M2F, GPIO_1_M2F, CNT_CLR and reads the
//            conditioned outputs (MSS / board side).
//   slave  : the conditioner itself.
// CNT_W must be set to the same value as the conditioner's CNT_W.
// ---------------------------------------------------------------------------
interface gpio_m2f_conditioner_if #(
    parameter int CNT_W = 16
);
    logic             MSS_READY;
    logic             GPIO_0_M2F;
    logic             GPIO_1_M2F;
    logic             CNT_CLR;
    logic [1:0]       GPIO_DB;
    logic [1:0]       RISE;
    logic [1:0]       FALL;
    logic             Y;
    logic             ACTIVE;
    logic [CNT_W-1:0] EVT_CNT0;
    logic [CNT_W-1:0] EVT_CNT1;

    modport master (
        output MSS_READY, GPIO_0_M2F, GPIO_1_M2F, CNT_CLR,
        input  GPIO_DB, RISE, FALL, Y, ACTIVE, EVT_CNT0, EVT_CNT1
    );

    modport slave (
        input  MSS_READY, GPIO_0_M2F, GPIO_1_M2F, CNT_CLR,
        output GPIO_DB, RISE, FALL, Y, ACTIVE, EVT_CNT0, EVT_CNT1
    );
endinterface

// File: rtl/gpio_m2f_conditioner.sv
// ---------------------------------------------------------------------------
// gpio_m2f_conditioner
// Fabric-side conditioning of the two MSS GPIO M2F lines: 2-flop resync,
// debounce, edge pulses, saturating per-channel edge counters and the
// registered NOR output Y. All outputs stay quiet until MSS_READY has been
// stable for SETTLE_CYCLES cycles.
// Ports:
//   FAB_CCC_GL0       fabric clock
//   POWER_ON_RESET_N  asynchronous active-low reset
//   bus (slave)       MSS_READY, GPIO_0_M2F, GPIO_1_M2F, CNT_CLR in;
//                     GPIO_DB, RISE, FALL, Y, ACTIVE, EVT_CNT0/1 out
// ---------------------------------------------------------------------------
module gpio_m2f_conditioner #(
    parameter int DB_CYCLES     = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_W         = 16
) (
    input  logic                    FAB_CCC_GL0,
    input  logic                    POWER_ON_RESET_N,
    gpio_m2f_conditioner_if.slave   bus
);
    localparam int DB_W = $clog2(DB_CYCLES);
    localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        SETTLE     = 2'd1,
        RUN        = 2'd2
    } state_e;

    state_e                     state_q;
    logic [ST_W-1:0]            settle_q;
    logic                       active_q;
    logic [1:0]                 gpio_meta_q, gpio_sync_q;
    logic                       rdy_meta_q, rdy_s_q;
    logic [1:0][DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic [1:0]                 db_q, db_d;
    logic [1:0]                 rise_q, rise_d;
    logic [1:0]                 fall_q, fall_d;
    logic                       y_q, y_d;
    logic [CNT_W-1:0]           cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                       settle_done_s;

    // Saturating event counter step; a clear always wins over an increment.
    function automatic logic [CNT_W-1:0] next_cnt(input logic clr,
                                                  input logic evt,
                                                  input logic [CNT_W-1:0] cur);
        logic [CNT_W-1:0] nxt;
        if (clr) begin
            nxt = {CNT_W{1'b0}};
        end else if (evt && (cur != CNT_MAX)) begin
            nxt = cur + CNT_W'(1'b1);
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // SETTLE is left on the edge where the settle counter reaches
    // SETTLE_CYCLES-1, so ACTIVE rises SETTLE_CYCLES edges after rdy_s.
    assign settle_done_s = (32'(settle_q) + 32'd1) >= 32'(SETTLE_CYCLES - 1);

    // Two-flop synchronisers for both GPIO lines and MSS_READY.
    always_ff @(posedge FAB_CCC_GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            gpio_meta_q <= 2'b00;
            gpio_sync_q <= 2'b00;
            rdy_meta_q  <= 1'b0;
            rdy_s_q     <= 1'b0;
        end else begin
            gpio_meta_q <= {bus.GPIO_1_M2F, bus.GPIO_0_M2F};
            gpio_sync_q <= gpio_meta_q;
            rdy_meta_q  <= bus.MSS_READY;
            rdy_s_q     <= rdy_meta_q;
        end
    end

    // Bring-up FSM with settle counter and registered ACTIVE flag.
    always_ff @(posedge FAB_CCC_GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            state_q  <= WAIT_READY;
            settle_q <= {ST_W{1'b0}};
            active_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_READY: begin
                    settle_q <= {ST_W{1'b0}};
                    active_q <= 1'b0;
                    if (rdy_s_q) begin
                        state_q <= SETTLE;
                    end else begin
                        state_q <= WAIT_READY;
                    end
                end
                SETTLE: begin
                    if (!rdy_s_q) begin
                        state_q  <= WAIT_READY;
                        settle_q <= {ST_W{1'b0}};
                        active_q <= 1'b0;
                    end else if (settle_done_s) begin
                        state_q  <= RUN;
                        settle_q <= {ST_W{1'b0}};
                        active_q <= 1'b1;
                    end else begin
                        state_q  <= SETTLE;
                        settle_q <= settle_q + ST_W'(1'b1);
                        active_q <= 1'b0;
                    end
                end
                RUN: begin
                    settle_q <= {ST_W{1'b0}};
                    if (!rdy_s_q) begin
                        state_q  <= WAIT_READY;
                        active_q <= 1'b0;
                    end else begin
                        state_q  <= RUN;
                        active_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= WAIT_READY;
                    settle_q <= {ST_W{1'b0}};
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Debounce and edge detection; GPIO_DB is forced to 0 outside RUN and is
    // loaded directly (no pulse) on the SETTLE->RUN transition.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        rise_d   = 2'b00;
        fall_d   = 2'b00;
        case (state_q)
            RUN: begin
                if (rdy_s_q) begin
                    for (int i = 0; i < 2; i++) begin
                        if (gpio_sync_q[i] == db_q[i]) begin
                            db_cnt_d[i] = {DB_W{1'b0}};
                        end else if (db_cnt_q[i] == DB_LAST) begin
                            db_d[i]     = gpio_sync_q[i];
                            db_cnt_d[i] = {DB_W{1'b0}};
                            rise_d[i]   = gpio_sync_q[i];
                            fall_d[i]   = ~gpio_sync_q[i];
                        end else begin
                            db_cnt_d[i] = db_cnt_q[i] + DB_W'(1'b1);
                        end
                    end
                end else begin
                    db_d     = 2'b00;
                    db_cnt_d = {(2*DB_W){1'b0}};
                end
            end
            SETTLE: begin
                db_cnt_d = {(2*DB_W){1'b0}};
                if (rdy_s_q && settle_done_s) begin
                    db_d = gpio_sync_q;
                end else begin
                    db_d = 2'b00;
                end
            end
            default: begin
                db_d     = 2'b00;
                db_cnt_d = {(2*DB_W){1'b0}};
            end
        endcase
    end

    // Y follows the debounced levels one cycle later; counters step on the
    // cycle after a pulse.
    always_comb begin
        y_d    = active_q & ~(db_q[0] | db_q[1]);
        cnt0_d = next_cnt(bus.CNT_CLR, rise_q[0] | fall_q[0], cnt0_q);
        cnt1_d = next_cnt(bus.CNT_CLR, rise_q[1] | fall_q[1], cnt1_q);
    end

    // Datapath registers.
    always_ff @(posedge FAB_CCC_GL0 or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            db_q     <= 2'b00;
            db_cnt_q <= {(2*DB_W){1'b0}};
            rise_q   <= 2'b00;
            fall_q   <= 2'b00;
            y_q      <= 1'b0;
            cnt0_q   <= {CNT_W{1'b0}};
            cnt1_q   <= {CNT_W{1'b0}};
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            y_q      <= y_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign bus.GPIO_DB  = db_q;
    assign bus.RISE     = rise_q;
    assign bus.FALL     = fall_q;
    assign bus.Y        = y_q;
    assign bus.ACTIVE   = active_q;
    assign bus.EVT_CNT0 = cnt0_q;
    assign bus.EVT_CNT1 = cnt1_q;
endmodule

// File: tb/tb_gpio_m2f_conditioner.sv
// ---------------------------------------------------------------------------
// tb_gpio_m2f_conditioner
// Directed bench for gpio_m2f_conditioner (DB_CYCLES=4, SETTLE_CYCLES=8,
// CNT_W=4). A window-based reference model predicts every output after
// each clock edge; a negedge process compares all outputs every cycle, and
// the stimulus sequence adds hand-computed literal checks at the key edges.
// "At edge e" means an input is changed 1 time unit after posedge e, so it
// is first sampled at edge e+1.
// ---------------------------------------------------------------------------
module tb_gpio_m2f_conditioner;
    localparam int DB = 4;
    localparam int ST = 8;
    localparam int CW = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    gpio_m2f_conditioner_if #(.CNT_W(CW)) bus ();

    gpio_m2f_conditioner #(
        .DB_CYCLES    (DB),
        .SETTLE_CYCLES(ST),
        .CNT_W        (CW)
    ) dut (
        .FAB_CCC_GL0     (clk),
        .POWER_ON_RESET_N(rst_n),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A synchronised value after edge t equals the pin seen at edge t-1.
    // ACTIVE(t): rdy_s was 1 after each of the previous ST edges.
    // GPIO_DB(t): 0 when inactive; the synchronised pins on the first active
    // edge; otherwise flips when the last DB synchronised samples all differ
    // from it while the block was active throughout.
    logic [1:0]    pin_prev;
    logic          rdy_prev;
    logic [1:0]    s_h   [DB];
    logic          act_h [DB];
    logic          rdy_h [ST];
    logic          e_act, e_y;
    logic [1:0]    e_db, e_rise, e_fall;
    logic [CW-1:0] e_c0, e_c1;

    always @(posedge clk or negedge rst_n) begin
        logic          n_act, flip;
        logic [1:0]    n_db, n_rise, n_fall;
        if (!rst_n) begin
            pin_prev = 2'b00; rdy_prev = 1'b0;
            for (int j = 0; j < DB; j++) begin s_h[j] = 2'b00; act_h[j] = 1'b0; end
            for (int j = 0; j < ST; j++) rdy_h[j] = 1'b0;
            e_act = 1'b0; e_y = 1'b0; e_db = 2'b00; e_rise = 2'b00; e_fall = 2'b00;
            e_c0 = '0; e_c1 = '0;
        end else begin
            n_act = 1'b1;
            for (int j = 0; j < ST; j++) n_act = n_act & rdy_h[j];
            if (!n_act) begin
                n_db = 2'b00;
            end else if (!act_h[0]) begin
                n_db = s_h[0];
            end else begin
                for (int i = 0; i < 2; i++) begin
                    flip = 1'b1;
                    for (int j = 0; j < DB; j++) flip = flip & act_h[j] & (s_h[j][i] != e_db[i]);
                    n_db[i] = flip ? ~e_db[i] : e_db[i];
                end
            end
            n_rise = (n_act && act_h[0]) ? (n_db & ~e_db) : 2'b00;
            n_fall = (n_act && act_h[0]) ? (~n_db & e_db) : 2'b00;
            e_y = act_h[0] & ~(e_db[0] | e_db[1]);
            if (bus.CNT_CLR) begin
                e_c0 = '0; e_c1 = '0;
            end else begin
                if ((e_rise[0] | e_fall[0]) && e_c0 != 4'd15) e_c0 = e_c0 + 4'd1;
                if ((e_rise[1] | e_fall[1]) && e_c1 != 4'd15) e_c1 = e_c1 + 4'd1;
            end
            e_db = n_db; e_rise = n_rise; e_fall = n_fall; e_act = n_act;
            for (int j = DB - 1; j > 0; j--) begin s_h[j] = s_h[j-1]; act_h[j] = act_h[j-1]; end
            for (int j = ST - 1; j > 0; j--) rdy_h[j] = rdy_h[j-1];
            s_h[0] = pin_prev; act_h[0] = n_act; rdy_h[0] = rdy_prev;
            pin_prev = {bus.GPIO_1_M2F, bus.GPIO_0_M2F};
            rdy_prev = bus.MSS_READY;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_active", 32'(bus.ACTIVE),   32'(e_act));
        chk("m_db",     32'(bus.GPIO_DB),  32'(e_db));
        chk("m_rise",   32'(bus.RISE),     32'(e_rise));
        chk("m_fall",   32'(bus.FALL),     32'(e_fall));
        chk("m_y",      32'(bus.Y),        32'(e_y));
        chk("m_cnt0",   32'(bus.EVT_CNT0), 32'(e_c0));
        chk("m_cnt1",   32'(bus.EVT_CNT1), 32'(e_c1));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_active"}, 32'(bus.ACTIVE),   32'd0);
        chk({tag, "_db"},     32'(bus.GPIO_DB),  32'd0);
        chk({tag, "_rise"},   32'(bus.RISE),     32'd0);
        chk({tag, "_fall"},   32'(bus.FALL),     32'd0);
        chk({tag, "_y"},      32'(bus.Y),        32'd0);
        chk({tag, "_cnt0"},   32'(bus.EVT_CNT0), 32'd0);
        chk({tag, "_cnt1"},   32'(bus.EVT_CNT1), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.MSS_READY = 1'b0; bus.GPIO_0_M2F = 1'b0; bus.GPIO_1_M2F = 1'b0; bus.CNT_CLR = 1'b0;
        #3;
        chk_all_zero("reset");
        #19 rst_n = 1'b1;
        step(2);

        // Bring-up: MSS_READY rises at edge k.
        step(1);
        bus.MSS_READY = 1'b1;
        step(9);
        chk("bringup_active_k9", 32'(bus.ACTIVE), 32'd0);
        step(1);
        chk("bringup_active_k10", 32'(bus.ACTIVE), 32'd1);
        chk("bringup_y_k10", 32'(bus.Y), 32'd0);
        step(1);
        chk("bringup_y_k11", 32'(bus.Y), 32'd1);
        chk("bringup_rise", 32'(bus.RISE), 32'd0);
        chk("bringup_cnt0", 32'(bus.EVT_CNT0), 32'd0);

        // Debounced rising edge on channel 0 at edge m.
        bus.GPIO_0_M2F = 1'b1;
        step(5);
        chk("db_m5", 32'(bus.GPIO_DB), 32'd0);
        step(1);
        chk("db_m6", 32'(bus.GPIO_DB), 32'd1);
        chk("rise_m6", 32'(bus.RISE), 32'd1);
        step(1);
        chk("rise_m7", 32'(bus.RISE), 32'd0);
        chk("y_m7", 32'(bus.Y), 32'd0);
        chk("cnt0_m7", 32'(bus.EVT_CNT0), 32'd1);

        // 3-cycle glitch on channel 1 is rejected.
        bus.GPIO_1_M2F = 1'b1;
        step(3);
        bus.GPIO_1_M2F = 1'b0;
        step(10);
        chk("glitch_db", 32'(bus.GPIO_DB), 32'd1);
        chk("glitch_cnt1", 32'(bus.EVT_CNT1), 32'd0);

        bus.GPIO_0_M2F = 1'b0;
        step(8);
        chk("fall0_cnt0", 32'(bus.EVT_CNT0), 32'd2);

        // Simultaneous edges on both channels.
        bus.GPIO_0_M2F = 1'b1; bus.GPIO_1_M2F = 1'b1;
        step(6);
        chk("sim_rise", 32'(bus.RISE), 32'd3);
        step(1);
        chk("sim_rise_off", 32'(bus.RISE), 32'd0);
        chk("sim_cnt0", 32'(bus.EVT_CNT0), 32'd3);
        chk("sim_cnt1", 32'(bus.EVT_CNT1), 32'd1);
        bus.GPIO_0_M2F = 1'b0; bus.GPIO_1_M2F = 1'b0;
        step(6);
        chk("sim_fall", 32'(bus.FALL), 32'd3);
        step(1);
        chk("sim_cnt0b", 32'(bus.EVT_CNT0), 32'd4);
        chk("sim_cnt1b", 32'(bus.EVT_CNT1), 32'd2);

        // Saturation: 20 more channel-0 edges.
        for (int n = 0; n < 20; n++) begin
            bus.GPIO_0_M2F = ~bus.GPIO_0_M2F;
            step(6);
        end
        step(2);
        chk("sat_cnt0", 32'(bus.EVT_CNT0), 32'd15);

        // Clear on the same cycle as a pending increment.
        bus.GPIO_0_M2F = 1'b1;
        step(6);
        chk("clr_rise", 32'(bus.RISE), 32'd1);
        bus.CNT_CLR = 1'b1;
        step(1);
        bus.CNT_CLR = 1'b0;
        chk("clr_cnt0", 32'(bus.EVT_CNT0), 32'd0);
        chk("clr_cnt1", 32'(bus.EVT_CNT1), 32'd0);

        bus.GPIO_0_M2F = 1'b0;
        step(8);
        bus.GPIO_0_M2F = 1'b1;
        step(8);
        chk("pre_loss_db", 32'(bus.GPIO_DB), 32'd1);

        // MSS_READY loss in RUN at edge r.
        bus.MSS_READY = 1'b0;
        step(2);
        chk("loss_active_r2", 32'(bus.ACTIVE), 32'd1);
        step(1);
        chk("loss_active_r3", 32'(bus.ACTIVE), 32'd0);
        chk("loss_db", 32'(bus.GPIO_DB), 32'd0);
        chk("loss_fall", 32'(bus.FALL), 32'd0);
        chk("loss_cnt0", 32'(bus.EVT_CNT0), 32'd2);
        step(1);
        chk("loss_y", 32'(bus.Y), 32'd0);

        // MSS_READY drop during SETTLE restarts the settle count.
        step(3);
        bus.MSS_READY = 1'b1;
        step(6);
        bus.MSS_READY = 1'b0;
        step(2);
        bus.MSS_READY = 1'b1;
        step(9);
        chk("resettle_k9", 32'(bus.ACTIVE), 32'd0);
        step(1);
        chk("resettle_k10", 32'(bus.ACTIVE), 32'd1);
        chk("resettle_db", 32'(bus.GPIO_DB), 32'd1);
        chk("resettle_rise", 32'(bus.RISE), 32'd0);

        // Asynchronous reset in the middle of a debounce.
        bus.GPIO_1_M2F = 1'b1;
        step(2);
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("areset");
        #3 rst_n = 1'b1;
        step(9);
        chk("rearm_k9", 32'(bus.ACTIVE), 32'd0);
        step(1);
        chk("rearm_k10", 32'(bus.ACTIVE), 32'd1);
        chk("rearm_db", 32'(bus.GPIO_DB), 32'd3);
        chk("rearm_rise", 32'(bus.RISE), 32'd0);
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
